// File: rtl/parity_pkg.sv
// Shared types and constants for the parity frame transmitter and its helpers.
package parity_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic PARITY_EVEN = 1'b1;
  localparam logic PARITY_ODD  = 1'b0;
  localparam int   FRAME_BITS  = 11;
  localparam int   DATA_BITS   = 8;

  // Everything captured from the producer at accept time.
  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 parity_type;
    logic                 parity_bit;
  } frame_t;

endpackage

// File: rtl/parity_checker.sv
// Receiver-side companion of parity_generator: flags whether a byte/parity pair is consistent.
module parity_checker
  import parity_pkg::*;
(
  input  logic [DATA_BITS-1:0] data,
  input  logic                 parity_type,
  input  logic                 parity_bit,
  output logic                 parity_ok
);

  logic expected_bit;

  assign expected_bit = (parity_type == PARITY_ODD) ? ~^data : ^data;
  assign parity_ok    = (expected_bit == parity_bit);

endmodule

// File: rtl/parity_generator.sv
// Combinational parity bit for one byte: even -> XOR of data, odd -> XNOR of data.
module parity_generator
  import parity_pkg::*;
(
  input  logic [DATA_BITS-1:0] data,
  input  logic                 parity_type,
  output logic                 parity_bit
);

  assign parity_bit = (parity_type == PARITY_EVEN) ? ^data : ~^data;

endmodule

// File: rtl/parity_serial_tx.sv
// Byte-in, serial-out frame controller: start, 8 data bits LSB first, parity, stop.
module parity_serial_tx
  import parity_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_parity_type,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     frames_sent
);

  localparam int             CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

  state_t        state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  frame_t        frame_reg;
  logic          gen_parity;
  logic          accept;
  logic          bit_end;
  logic          unused_parity_type;

  parity_generator u_gen (
    .data        (in_data),
    .parity_type (in_parity_type),
    .parity_bit  (gen_parity)
  );

  assign in_ready = (state == IDLE) && rst_n;
  assign accept   = in_valid && in_ready;
  assign bit_end  = (clk_cnt == CNT_LAST);

  // The latched type is kept alongside the byte for debug visibility only.
  assign unused_parity_type = frame_reg.parity_type;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      frame_reg   <= '0;
      tx_out      <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      frames_sent <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        tx_out <= 1'b1;
        busy   <= 1'b0;
        if (accept) begin
          frame_reg <= '{data: in_data, parity_type: in_parity_type, parity_bit: gen_parity};
          state     <= START;
          clk_cnt   <= '0;
          tx_out    <= 1'b0;
          busy      <= 1'b1;
        end
      end else if (!bit_end) begin
        clk_cnt <= clk_cnt + 1'b1;
      end else begin
        // Bit boundary: tx_out is loaded with the next bit so the line never glitches.
        clk_cnt <= '0;
        case (state)
          START: begin
            state   <= DATA;
            bit_cnt <= '0;
            tx_out  <= frame_reg.data[0];
          end
          DATA: begin
            if (bit_cnt == BIT_LAST) begin
              state  <= PARITY;
              tx_out <= frame_reg.parity_bit;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_out  <= frame_reg.data[bit_cnt + 1'b1];
            end
          end
          PARITY: begin
            state  <= STOP;
            tx_out <= 1'b1;
          end
          STOP: begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b1;
            frames_sent <= frames_sent + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed bench for parity_serial_tx: frame timing, parity, held stimulus, abort and counter wrap.
module tb_parity_serial_tx;
  import parity_pkg::*;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_parity_type = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready, tx_out, busy, done;
  logic [15:0] frames_sent;

  logic        w_in_valid = 1'b0;
  logic [7:0]  w_in_data = '0;
  logic        w_in_ready, w_tx_out, w_busy, w_done;
  logic [1:0]  w_frames_sent;

  logic [7:0]  rx_data = '0;
  logic        rx_type = 1'b0;
  logic        rx_par = 1'b0;
  logic        rx_ok;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_frames = '0;

  always #5 clk = ~clk;

  parity_serial_tx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_parity_type(in_parity_type),
    .in_valid(in_valid), .in_ready(in_ready), .tx_out(tx_out), .busy(busy),
    .done(done), .frames_sent(frames_sent)
  );

  parity_serial_tx #(.CLKS_PER_BIT(1), .CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_data(w_in_data), .in_parity_type(1'b1),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .tx_out(w_tx_out), .busy(w_busy),
    .done(w_done), .frames_sent(w_frames_sent)
  );

  parity_checker u_chk (
    .data(rx_data), .parity_type(rx_type), .parity_bit(rx_par), .parity_ok(rx_ok)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Send one byte and follow it to its done cycle; returns with the bench parked on the done cycle.
  task automatic run_frame(input logic [7:0] d, input logic pt, input logic exp_par, input logic hold);
    logic [10:0] exp_bits;
    logic [10:0] rx_bits;
    int          waited;
    exp_bits = {1'b1, exp_par, d, 1'b0};
    rx_bits  = '0;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check_eq("ready_before_accept", 32'(in_ready), 32'd1);
    in_data = d;
    in_parity_type = pt;
    in_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < FRAME_BITS * CPB; i++) begin
      @(negedge clk);
      if (hold) begin
        in_data = ~in_data;
        in_parity_type = ~in_parity_type;
      end else begin
        in_valid = 1'b0;
      end
      check_eq($sformatf("tx_bit%0d", i / CPB), 32'(tx_out), 32'(exp_bits[i / CPB]));
      check_eq("busy_in_frame", 32'(busy), 32'd1);
      check_eq("done_early", 32'(done), 32'd0);
      check_eq("ready_in_frame", 32'(in_ready), 32'd0);
      if (i % CPB == CPB / 2) rx_bits[i / CPB] = tx_out;
    end
    @(negedge clk);
    exp_frames++;
    check_eq("done_pulse", 32'(done), 32'd1);
    check_eq("busy_after", 32'(busy), 32'd0);
    check_eq("ready_in_done", 32'(in_ready), 32'd1);
    check_eq("frames_sent", 32'(frames_sent), 32'(exp_frames));
    rx_data = rx_bits[8:1];
    rx_par  = rx_bits[9];
    rx_type = pt;
    #1;
    check_eq("rx_data", 32'(rx_data), 32'(d));
    check_eq("rx_parity_ok", 32'(rx_ok), 32'd1);
    $display("frame data=0x%02h type=%0d rx=0x%02h par=%0d ok=%0d frames_sent=%0d",
             d, pt, rx_data, rx_par, rx_ok, frames_sent);
  endtask

  initial begin
    // Reset state, with a producer already asking
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", 32'(tx_out), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_frames", 32'(frames_sent), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check_eq("ready_after_rst", 32'(in_ready), 32'd1);
    @(negedge clk);

    // 0xA5 even: four ones -> parity 0
    run_frame(8'hA5, PARITY_EVEN, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("done_once", 32'(done), 32'd0);
    check_eq("idle_tx", 32'(tx_out), 32'd1);

    // Parity coverage, sent back to back
    run_frame(8'h03, PARITY_ODD,  1'b1, 1'b0);
    run_frame(8'hFF, PARITY_ODD,  1'b1, 1'b0);
    run_frame(8'h00, PARITY_EVEN, 1'b0, 1'b0);
    run_frame(8'h07, PARITY_EVEN, 1'b1, 1'b0);

    // Held/toggling stimulus, then the next byte accepted in the done cycle
    run_frame(8'h3C, PARITY_ODD,  1'b1, 1'b1);
    run_frame(8'h81, PARITY_EVEN, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("done_after_chain", 32'(done), 32'd0);

    // Abort during DATA bit 3 of 0x00 (line low there)
    in_data = 8'h00;
    in_parity_type = PARITY_EVEN;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (17) @(negedge clk);
    check_eq("abort_pre_tx", 32'(tx_out), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    exp_frames = '0;
    check_eq("abort_tx", 32'(tx_out), 32'd1);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_frames", 32'(frames_sent), 32'd0);
    check_eq("abort_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("abort_no_done", 32'(done), 32'd0);
      check_eq("abort_idle_tx", 32'(tx_out), 32'd1);
    end
    run_frame(8'h5A, PARITY_EVEN, 1'b0, 1'b0);
    @(negedge clk);

    // Counter wrap on the CNT_W=2, one-clock-per-bit instance
    for (int f = 1; f <= 5; f++) begin
      int n;
      int waited;
      waited = 0;
      while (w_in_ready !== 1'b1 && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      w_in_data = 8'(f * 37);
      w_in_valid = 1'b1;
      @(posedge clk);
      n = 0;
      while (n < 40) begin
        @(negedge clk);
        w_in_valid = 1'b0;
        n++;
        if (n == 1) check_eq("w_start_bit", 32'(w_tx_out), 32'd0);
        if (w_done === 1'b1) break;
      end
      check_eq($sformatf("w_latency_f%0d", f), 32'(n), 32'(FRAME_BITS + 1));
      check_eq($sformatf("w_frames_f%0d", f), 32'(w_frames_sent), 32'(f % 4));
      $display("wrap frame %0d data=0x%02h done_after=%0d frames_sent=%0d", f, w_in_data, n, w_frames_sent);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/parity_serial_tx.md
Name: parity_serial_tx

Overview:
Frame controller that sequences the team's parity generator onto a serial line. It accepts one byte per valid/ready handshake and computes its parity bit with parity_generator. It then shifts out a fixed frame: start bit, 8 data bits LSB first, parity bit, stop bit. It sits between a byte-stream producer and the serial pad; the downstream receiver uses parity_checker.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit; legal range >= 1.
CNT_W, 16, width of the frames_sent counter; legal range >= 1.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  8  byte to transmit
in_parity_type  input  1  1 = even (parity bit = XOR of data), 0 = odd (parity bit = XNOR of data)
in_valid  input  1  producer has a byte
in_ready  output  1  block can accept a byte this cycle
tx_out  output  1  serial line, idle high
busy  output  1  a frame is in progress
done  output  1  one-cycle pulse after a frame completes
frames_sent  output  CNT_W  count of completed frames, wraps

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, tx_out = 1, busy = 0, done = 0, frames_sent = 0, all counters = 0.
- in_ready = (state == IDLE) && rst_n. It is combinational, so it is 0 while reset is asserted.
- Accept happens when in_valid && in_ready at a rising edge.
- On accept, latch in_data, in_parity_type and the parity bit from parity_generator into registers.
- After accept, in_data and in_parity_type changes are ignored until the next accept.
- State IDLE:
  - tx_out = 1, busy = 0.
  - On accept, go to START; clk_cnt = 0.
- State START: tx_out = 0 for CLKS_PER_BIT cycles, then go to DATA with bit_cnt = 0.
- State DATA:
  - tx_out = data[bit_cnt], CLKS_PER_BIT cycles per bit.
  - bit_cnt increments 0 to 7; after bit 7 go to PARITY.
- State PARITY: tx_out = latched parity bit for CLKS_PER_BIT cycles.
- State STOP: tx_out = 1 for CLKS_PER_BIT cycles, then go to IDLE.
- Leaving STOP:
  - done is registered high for exactly the first IDLE cycle.
  - frames_sent increments by 1 modulo 2^CNT_W in that same cycle.
- busy = 1 in START, DATA, PARITY and STOP. tx_out is registered (glitch-free).
- clk_cnt counts 0 to CLKS_PER_BIT-1 and resets to 0 on every bit boundary. With CLKS_PER_BIT = 1, each bit lasts exactly one cycle.
- Latency, with accept at edge k:
  - start bit is on the line in cycles k+1 .. k+CLKS_PER_BIT;
  - stop bit ends at k+11*CLKS_PER_BIT;
  - done is high in cycle k+11*CLKS_PER_BIT+1.
- Back-to-back frames: in_ready is high during the done cycle. An accept there starts the next start bit one cycle later, giving a minimum inter-frame gap of 1 idle clock.
- in_valid held or changed during a frame: no effect and no accept.
- Reset mid-frame: the frame is aborted immediately and the line returns high. No done pulse is produced, and the partial frame is not counted.

Decomposition:
- Package parity_pkg holds:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - PARITY_EVEN = 1'b1 and PARITY_ODD = 1'b0;
  - FRAME_BITS = 11 and DATA_BITS = 8.
- Sub-module: instantiate the existing parity_generator on in_data and in_parity_type. Its output is captured at accept. No new parity logic is written in this block.

Test Plan:
1. Reset with CLKS_PER_BIT=4:
   - during reset: tx_out=1, busy=0, done=0, frames_sent=0, in_ready=0;
   - after release: in_ready=1.
2. Send 0xA5, in_parity_type=1, accept at k:
   - line sequence, each bit held 4 cycles: 0 | 1,0,1,0,0,1,0,1 | parity 0 | 1;
   - done high at k+45 and nowhere else; frames_sent=1.
3. Parity coverage:
   - 0x03 odd gives parity bit 1; 0xFF odd gives 1;
   - 0x00 even gives 0; 0x07 even gives 1.
   - Each frame's bits are checked by a bench model built on parity_checker, which must report parity_ok=1.
4. Stimulus held during a frame:
   - hold in_valid=1 and toggle in_data and in_parity_type every cycle during the frame; require in_ready=0 and no change to the frame;
   - the second byte is accepted in the done cycle (k+45), and its start bit appears at k+46.
5. Reset mid-frame:
   - assert rst_n=0 during DATA bit 3; tx_out goes to 1 asynchronously, busy=0, frames_sent=0;
   - after release, a fresh 0x5A frame transmits correctly.
6. Counter wrap with CNT_W=2: after 4 completed frames frames_sent=0, and after the 5th it is 1.
